// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scanner: FSM states, segment
// bit order {g,f,e,d,c,b,a} (bit 0 = a) and active-high digit patterns.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_e;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ssd_decoder.sv
// Combinational BCD to seven-segment decoder; non-decimal codes show nothing.
module ssd_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Lookup of the segment pattern for one BCD nibble.
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment display scanner with a one-deep load buffer.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shows).
module seven_segment_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    loadValid,
    input  logic [4*NUM_DIGITS-1:0] loadValue,
    output logic                    loadReady,
    output logic [6:0]              segOut,
    output logic [NUM_DIGITS-1:0]   digitEn,
    output logic                    frameStart
);

    localparam int CNT_MAX = max_int(REFRESH_DIV, BLANK_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int DISP_W  = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO   = {IDX_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

    scan_state_e           state_r, state_s;
    logic [IDX_W-1:0]      idx_r, idx_s, next_idx_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [DISP_W-1:0]     disp_r, disp_s, pend_r;
    logic                  pend_full_r, full_s;
    logic                  load_ready_r;
    logic                  accept_s, transfer_s, drive_start_s;
    logic [6:0]            seg_r, seg_s, dec_seg_s;
    logic [NUM_DIGITS-1:0] digit_en_r, digit_en_s;
    logic                  frame_r, frame_s;
    logic [3:0]            nibble_s;
    logic                  lz_blank_s;

    assign next_idx_s = (idx_r == IDX_LAST) ? IDX_ZERO : (idx_r + IDX_W'(1));

    // Scan sequencing: next state, digit index and dwell counter.
    always_comb begin
        state_s       = state_r;
        idx_s         = idx_r;
        cnt_s         = cnt_r;
        drive_start_s = 1'b0;
        if (!enable) begin
            state_s = ST_IDLE;
            idx_s   = IDX_ZERO;
            cnt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s       = ST_DRIVE;
                    idx_s         = IDX_ZERO;
                    cnt_s         = CNT_ZERO;
                    drive_start_s = 1'b1;
                end
                ST_DRIVE: begin
                    if (cnt_r == DRIVE_LAST) begin
                        cnt_s = CNT_ZERO;
                        if (BLANK_CYCLES == 0) begin
                            state_s       = ST_DRIVE;
                            idx_s         = next_idx_s;
                            drive_start_s = 1'b1;
                        end else begin
                            state_s = ST_BLANK;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_BLANK: begin
                    if (cnt_r == BLANK_LAST) begin
                        state_s       = ST_DRIVE;
                        idx_s         = next_idx_s;
                        cnt_s         = CNT_ZERO;
                        drive_start_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    idx_s   = IDX_ZERO;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Display only changes at a frame boundary, so a frame never mixes two values.
    assign transfer_s = drive_start_s && (idx_s == IDX_ZERO) && pend_full_r;
    assign accept_s   = loadValid && load_ready_r;
    assign disp_s     = transfer_s ? pend_r : disp_r;
    assign full_s     = transfer_s ? 1'b0 : (accept_s ? 1'b1 : pend_full_r);
    assign nibble_s   = disp_s[4*int'(idx_s) +: 4];

    ssd_decoder u_decoder (
        .bcd (nibble_s),
        .seg (dec_seg_s)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is suppressed when it and every more significant digit are zero.
    always_comb begin
        lz_blank_s = (idx_s != IDX_ZERO);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((i >= int'(idx_s)) && (disp_s[4*i +: 4] != 4'd0)) begin
                lz_blank_s = 1'b0;
            end else begin
                lz_blank_s = lz_blank_s;
            end
        end
    end
`else
    assign lz_blank_s = 1'b0;
`endif

    assign seg_s      = ((state_s == ST_DRIVE) && !lz_blank_s) ? dec_seg_s : SEG_BLANK;
    assign digit_en_s = (state_s == ST_DRIVE) ? (NUM_DIGITS'(1) << idx_s) : {NUM_DIGITS{1'b0}};
    assign frame_s    = drive_start_s && (idx_s == IDX_ZERO);

    // State, buffer and output registers; reset darkens the display immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= IDX_ZERO;
            cnt_r        <= CNT_ZERO;
            disp_r       <= {DISP_W{1'b0}};
            pend_r       <= {DISP_W{1'b0}};
            pend_full_r  <= 1'b0;
            load_ready_r <= 1'b1;
            seg_r        <= SEG_BLANK;
            digit_en_r   <= {NUM_DIGITS{1'b0}};
            frame_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            cnt_r        <= cnt_s;
            disp_r       <= disp_s;
            pend_r       <= accept_s ? loadValue : pend_r;
            pend_full_r  <= full_s;
            load_ready_r <= !full_s;
            seg_r        <= seg_s;
            digit_en_r   <= digit_en_s;
            frame_r      <= frame_s;
        end
    end

    assign loadReady  = load_ready_r;
    assign segOut     = seg_r;
    assign digitEn    = digit_en_r;
    assign frameStart = frame_r;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner (4 digits, 4-cycle drive, 1 blank cycle).
// Builds with or without LEADING_ZERO_BLANK_EN; expected patterns follow the build.
module tb_seven_segment_scanner;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        loadValid;
    logic [15:0] loadValue;
    logic        loadReady;
    logic [6:0]  segOut;
    logic [3:0]  digitEn;
    logic        frameStart;

    int checks = 0;
    int passes = 0;

    // Patterns packed {digit3, digit2, digit1, digit0}, 7 bits each.
    localparam logic [27:0] P1234 = {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110};
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [27:0] P0008 = {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111111};
    localparam logic [27:0] P0A56 = {7'b0000000, 7'b0000000, 7'b1101101, 7'b1111101};
    localparam logic [27:0] P0000 = {7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111};
    localparam logic [27:0] P0050 = {7'b0000000, 7'b0000000, 7'b1101101, 7'b0111111};
`else
    localparam logic [27:0] P0008 = {7'b0111111, 7'b0111111, 7'b0111111, 7'b1111111};
    localparam logic [27:0] P0A56 = {7'b0111111, 7'b0000000, 7'b1101101, 7'b1111101};
    localparam logic [27:0] P0000 = {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    localparam logic [27:0] P0050 = {7'b0111111, 7'b0111111, 7'b1101101, 7'b0111111};
`endif

    seven_segment_scanner #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .loadValid  (loadValid),
        .loadValue  (loadValue),
        .loadReady  (loadReady),
        .segOut     (segOut),
        .digitEn    (digitEn),
        .frameStart (frameStart)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_seg"}, 32'(segOut), 32'd0);
        check({tag, "_den"}, 32'(digitEn), 32'd0);
        check({tag, "_fs"}, 32'(frameStart), 32'd0);
    endtask

    // Walks ndig digits (drive + blank each) from a frame start, optionally
    // offering a load at the start of digit 1.
    task automatic run_frame(input logic [27:0] pats, input int ndig,
                             input bit do_load, input logic [15:0] val);
        for (int d = 0; d < ndig; d++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (do_load && d == 1 && c == 1) begin
                    loadValid = 1'b0;
                    check("ready_low_after_capture", 32'(loadReady), 32'd0);
                end
                if (d == 0 && c == 0) begin
                    check("ready_at_frame_start", 32'(loadReady), 32'd1);
                end
                check("drive_den", 32'(digitEn), 32'(4'b0001 << d));
                check("drive_seg", 32'(segOut), 32'(pats[7*d +: 7]));
                check("drive_fs", 32'(frameStart), (d == 0 && c == 0) ? 32'd1 : 32'd0);
                if (do_load && d == 1 && c == 0) begin
                    loadValid = 1'b1;
                    loadValue = val;
                end
            end
            @(negedge clk);
            check_dark("blank");
        end
        if (do_load) begin
            check("ready_low_until_transfer", 32'(loadReady), 32'd0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        loadValid = 1'b0;
        loadValue = 16'h0000;
        #12;
        check_dark("reset");
        check("reset_ready", 32'(loadReady), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Load while disabled, then start scanning.
        loadValid = 1'b1;
        loadValue = 16'h1234;
        @(negedge clk);
        loadValid = 1'b0;
        check("ready_low_idle", 32'(loadReady), 32'd0);
        check_dark("idle");
        enable = 1'b1;
        run_frame(P1234, 4, 1'b0, 16'h0000);

        // Mid-frame load does not disturb the current frame.
        run_frame(P1234, 4, 1'b1, 16'h0008);
        run_frame(P0008, 4, 1'b1, 16'h0A56);
        run_frame(P0A56, 4, 1'b0, 16'h0000);

        // Drop enable while digit 2 (nibble A) is driven.
        run_frame(P0A56, 2, 1'b0, 16'h0000);
        @(negedge clk);
        check("digit2_den", 32'(digitEn), 32'h4);
        check("digit2_hex_a_dark", 32'(segOut), 32'h00);
        enable = 1'b0;
        @(negedge clk);
        check_dark("disabled");
        @(negedge clk);
        check_dark("disabled_hold");
        enable = 1'b1;
        run_frame(P0A56, 4, 1'b0, 16'h0000);

        // Asynchronous reset mid-drive with a value pending.
        run_frame(P0A56, 1, 1'b0, 16'h0000);
        @(negedge clk);
        check("digit1_den", 32'(digitEn), 32'h2);
        loadValid = 1'b1;
        loadValue = 16'h9999;
        @(negedge clk);
        loadValid = 1'b0;
        check("pending_before_reset", 32'(loadReady), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_dark("async_reset");
        check("async_reset_ready", 32'(loadReady), 32'd1);
        #1 rst_n = 1'b1;

        // Cleared display and discarded pending show as zeros.
        run_frame(P0000, 4, 1'b1, 16'h0050);
        run_frame(P0050, 4, 1'b0, 16'h0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
